// File: rtl/andor_pkg.sv
// Shared definitions for the AND/OR checker.
// Holds the default operand/counter widths and the run-control state encoding
// used by andor_checker and andor_golden.
package andor_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/andor_golden.sv
// Golden reference for the unit under test: bitwise AND and OR of the operands.
// Ports:
//   x, y            captured stimulus operands (WIDTH bits each)
//   and_out, or_out expected AND / OR results (WIDTH bits each)
module andor_golden
  import andor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out
);

  assign and_out = x & y;
  assign or_out  = x | y;

endmodule

// File: rtl/andor_checker.sv
// Run-controlled checker for an AND/OR unit under test.
// Samples (x, y, and_in, or_in) are captured into a one-deep stage while the
// run is active and compared against the golden AND/OR one cycle later.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start, stop           run control
//   in_valid              qualifies x, y, and_in, or_in
//   x, y                  stimulus operands (WIDTH bits)
//   and_in, or_in         unit-under-test results (WIDTH bits)
//   busy, done, pass      run status (all registered)
//   vec_count, err_count  saturating sample / mismatch counters (CNT_W bits)
//   first_err_*           operands of the first mismatch of the run
module andor_checker
  import andor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] and_in,
  input  logic [WIDTH-1:0] or_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] OP_ZERO  = {WIDTH{1'b0}};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t           state_r, state_s;
  logic             cap_valid_r, cap_valid_s;
  logic [WIDTH-1:0] cap_x_r, cap_x_s;
  logic [WIDTH-1:0] cap_y_r, cap_y_s;
  logic [WIDTH-1:0] cap_and_r, cap_and_s;
  logic [WIDTH-1:0] cap_or_r, cap_or_s;
  logic [CNT_W-1:0] vec_s, err_s;
  logic             fev_s;
  logic [WIDTH-1:0] fex_s, fey_s;
  logic [WIDTH-1:0] gold_and_s, gold_or_s;
  logic             mismatch_s;

  andor_golden #(.WIDTH(WIDTH)) u_golden (
    .x       (cap_x_r),
    .y       (cap_y_r),
    .and_out (gold_and_s),
    .or_out  (gold_or_s)
  );

  assign mismatch_s = (cap_and_r != gold_and_s) || (cap_or_r != gold_or_s);

  // Next-state, capture stage and counter update logic.
  always_comb begin
    state_s     = state_r;
    cap_valid_s = 1'b0;
    cap_x_s     = cap_x_r;
    cap_y_s     = cap_y_r;
    cap_and_s   = cap_and_r;
    cap_or_s    = cap_or_r;
    vec_s       = vec_count;
    err_s       = err_count;
    fev_s       = first_err_valid;
    fex_s       = first_err_x;
    fey_s       = first_err_y;

    // The stage only fills in RUN, so this retires it in RUN or DRAIN.
    if (cap_valid_r) begin
      vec_s = sat_inc(vec_count);
      if (mismatch_s) begin
        err_s = sat_inc(err_count);
        if (!first_err_valid) begin
          fev_s = 1'b1;
          fex_s = cap_x_r;
          fey_s = cap_y_r;
        end else begin
          fev_s = first_err_valid;
        end
      end else begin
        err_s = err_count;
      end
    end else begin
      vec_s = vec_count;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Start wins over stop; a new run begins with clean results.
        if (start) begin
          state_s = ST_RUN;
          vec_s   = CNT_ZERO;
          err_s   = CNT_ZERO;
          fev_s   = 1'b0;
          fex_s   = OP_ZERO;
          fey_s   = OP_ZERO;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          cap_valid_s = 1'b1;
          cap_x_s     = x;
          cap_y_s     = y;
          cap_and_s   = and_in;
          cap_or_s    = or_in;
        end else begin
          cap_valid_s = 1'b0;
        end
        if (stop) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, capture stage and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      cap_valid_r     <= 1'b0;
      cap_x_r         <= OP_ZERO;
      cap_y_r         <= OP_ZERO;
      cap_and_r       <= OP_ZERO;
      cap_or_r        <= OP_ZERO;
      vec_count       <= CNT_ZERO;
      err_count       <= CNT_ZERO;
      first_err_valid <= 1'b0;
      first_err_x     <= OP_ZERO;
      first_err_y     <= OP_ZERO;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state_r         <= state_s;
      cap_valid_r     <= cap_valid_s;
      cap_x_r         <= cap_x_s;
      cap_y_r         <= cap_y_s;
      cap_and_r       <= cap_and_s;
      cap_or_r        <= cap_or_s;
      vec_count       <= vec_s;
      err_count       <= err_s;
      first_err_valid <= fev_s;
      first_err_x     <= fex_s;
      first_err_y     <= fey_s;
      busy            <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done            <= (state_s == ST_DONE);
      pass            <= (state_s == ST_DONE) && (err_s == CNT_ZERO) && (vec_s != CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_andor_checker.sv
// Directed bench for andor_checker: two instances (CNT_W=8 and CNT_W=2) share
// the stimulus; a sample-queue model predicts every output each cycle.
module tb_andor_checker;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, stop, in_valid;
  logic [W-1:0] x, y, and_in, or_in;

  logic         busy8, done8, pass8, fev8;
  logic [7:0]   vec8, err8;
  logic [W-1:0] fex8, fey8;
  logic         busy2, done2, pass2, fev2;
  logic [1:0]   vec2, err2;
  logic [W-1:0] fex2, fey2;

  andor_checker #(.WIDTH(W), .CNT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .in_valid(in_valid),
    .x(x), .y(y), .and_in(and_in), .or_in(or_in),
    .busy(busy8), .done(done8), .pass(pass8), .vec_count(vec8), .err_count(err8),
    .first_err_valid(fev8), .first_err_x(fex8), .first_err_y(fey8)
  );

  andor_checker #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .in_valid(in_valid),
    .x(x), .y(y), .and_in(and_in), .or_in(or_in),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec2), .err_count(err2),
    .first_err_valid(fev2), .first_err_x(fex2), .first_err_y(fey2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- model ----------------
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;
  typedef struct { logic [W-1:0] sx, sy, sa, so; } sample_t;

  phase_t       m_phase = P_IDLE;
  sample_t      pipe[$];
  int           m_vec = 0, m_err = 0;
  bit           m_fev = 1'b0;
  logic [W-1:0] m_fex = '0, m_fey = '0;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    pipe.delete();
    m_vec = 0; m_err = 0; m_fev = 1'b0; m_fex = '0; m_fey = '0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_step();
    sample_t s;
    if (pipe.size() > 0) begin
      s = pipe.pop_front();
      m_vec++;
      if (s.sa != (s.sx & s.sy) || s.so != (s.sx | s.sy)) begin
        m_err++;
        if (!m_fev) begin m_fev = 1'b1; m_fex = s.sx; m_fey = s.sy; end
      end
    end
    case (m_phase)
      P_IDLE, P_DONE: if (start) begin
        m_phase = P_RUN; m_vec = 0; m_err = 0; m_fev = 1'b0; m_fex = '0; m_fey = '0;
        pipe.delete();
      end
      P_RUN: begin
        if (in_valid) begin
          s.sx = x; s.sy = y; s.sa = and_in; s.so = or_in;
          pipe.push_back(s);
        end
        if (stop) m_phase = P_DRAIN;
      end
      P_DRAIN: m_phase = P_DONE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input int maxv,
                         input logic b, input logic d, input logic p,
                         input int v, input int e,
                         input logic fv, input logic [W-1:0] fx, input logic [W-1:0] fy);
    int ev, ee;
    ev = sat(m_vec, maxv);
    ee = sat(m_err, maxv);
    chk({tag, ".busy"}, int'(b), int'(m_phase == P_RUN || m_phase == P_DRAIN));
    chk({tag, ".done"}, int'(d), int'(m_phase == P_DONE));
    chk({tag, ".pass"}, int'(p), int'(m_phase == P_DONE && ee == 0 && ev != 0));
    chk({tag, ".vec"}, v, ev);
    chk({tag, ".err"}, e, ee);
    chk({tag, ".fev"}, int'(fv), int'(m_fev));
    chk({tag, ".fex"}, int'(fx), int'(m_fex));
    chk({tag, ".fey"}, int'(fy), int'(m_fey));
  endtask

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    cmp_dut("d8", 255, busy8, done8, pass8, int'(vec8), int'(err8), fev8, fex8, fey8);
    cmp_dut("d2", 3,   busy2, done2, pass2, int'(vec2), int'(err2), fev2, fex2, fey2);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic s, input logic p, input logic v,
                     input logic [W-1:0] vx, input logic [W-1:0] vy,
                     input logic [W-1:0] va, input logic [W-1:0] vo);
    start = s; stop = p; in_valid = v; x = vx; y = vy; and_in = va; or_in = vo;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    chk("rst.busy", int'(busy8), 0);
    chk("rst.done", int'(done8), 0);
    chk("rst.vec", int'(vec8), 0);
    chk("rst.err", int'(err8), 0);
    chk("rst.fev", int'(fev8), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    x = 2'b00; y = 2'b00; and_in = 2'b00; or_in = 2'b00;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("init.busy", int'(busy8), 0);
    chk("init.pass", int'(pass8), 0);

    // stop in IDLE is ignored
    cyc(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    chk("idle_stop.busy", int'(busy8), 0);

    // all-matching run
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("run.busy", int'(busy8), 1);
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b10);
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 2'b10);
    cyc(1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 2'b01, 2'b11);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    idle(2);
    chk("t1.done", int'(done8), 1);
    chk("t1.vec", int'(vec8), 3);
    chk("t1.err", int'(err8), 0);
    chk("t1.pass", int'(pass8), 1);

    // two mismatches, restart from DONE
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b01, 2'b11);
    cyc(1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b10);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    idle(2);
    chk("t2.err", int'(err8), 2);
    chk("t2.fex", int'(fex8), 2);
    chk("t2.fey", int'(fey8), 1);
    chk("t2.pass", int'(pass8), 0);

    // empty run
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("t3.drain_busy", int'(busy8), 1);
    chk("t3.drain_done", int'(done8), 0);
    idle(1);
    chk("t3.done", int'(done8), 1);
    chk("t3.vec", int'(vec8), 0);
    chk("t3.pass", int'(pass8), 0);

    // five samples, start ignored in RUN, CNT_W=2 saturates
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b11);
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b11);
    cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01);
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 2'b11);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    idle(2);
    chk("t4.vec2", int'(vec2), 3);
    chk("t4.pass2", int'(pass2), 1);
    chk("t4.vec8", int'(vec8), 5);

    // stop with mismatching sample; in_valid in DRAIN/DONE ignored
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01);
    cyc(1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b01);
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 2'b11);
    cyc(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b11);
    idle(1);
    chk("t5.vec", int'(vec8), 2);
    chk("t5.err", int'(err8), 1);
    chk("t5.fex", int'(fex8), 1);
    chk("t5.fey", int'(fey8), 0);

    // reset mid-run with a sample in the capture stage
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
    do_reset();
    chk("t6.vec", int'(vec8), 0);
    chk("t6.err", int'(err8), 0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b10, 2'b11);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    idle(2);
    chk("t6.vec_after", int'(vec8), 1);
    chk("t6.err_after", int'(err8), 0);
    chk("t6.fev_after", int'(fev8), 0);
    chk("t6.pass_after", int'(pass8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/andor_checker.md
ANDOR_CHECKER -- requirements
Module: andor_checker

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the operand and result width in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the vector and error counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  input  1  SHALL request a new check run.
REQ-006 stop  input  1  SHALL request the end of the current run.
REQ-007 in_valid  input  1  SHALL qualify x, y, and_in, or_in for one sample per cycle.
REQ-008 x, y  input  WIDTH each  SHALL be the stimulus operands applied to the unit under test.
REQ-009 and_in, or_in  input  WIDTH each  SHALL be the unit-under-test AND and OR results.
REQ-010 busy  output  1  SHALL be high in RUN and DRAIN.
REQ-011 done  output  1  SHALL be high in DONE.
REQ-012 pass  output  1  SHALL be high in DONE iff err_count==0 and vec_count!=0.
REQ-013 vec_count, err_count  output  CNT_W each  SHALL count accepted samples and mismatching samples.
REQ-014 first_err_valid  output  1; first_err_x, first_err_y  output  WIDTH each  SHALL report the operands of the first mismatch of the run.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL move to RUN and clear counters and first_err_* on the same edge; stop in IDLE SHALL be ignored; start and stop together SHALL act as start.
REQ-017 RUN: each edge with in_valid=1 SHALL register the sample into a capture stage (stage 1).
REQ-018 A sample in stage 1 SHALL be compared against golden x&y and x|y; vec_count SHALL increment, and err_count SHALL increment on any bit mismatch, one edge after capture (latency 1).
REQ-019 A mismatch SHALL load first_err_x/y and set first_err_valid only if first_err_valid is 0.
REQ-020 Counters SHALL saturate at all-ones and never wrap.
REQ-021 RUN: stop=1 SHALL move to DRAIN; a sample valid on that same edge SHALL still be captured and checked.
REQ-022 RUN: start SHALL be ignored.
REQ-023 DRAIN SHALL last exactly one cycle, completing the stage-1 comparison, then move to DONE; in_valid SHALL be ignored in DRAIN.
REQ-024 DONE: outputs SHALL hold stable; in_valid and stop ignored; start=1 SHALL move to RUN with counters cleared as in IDLE.
REQ-025 in_valid outside RUN SHALL never alter any counter or capture register.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, counters=0, first_err_valid=0, first_err_x/y=0, stage 1 empty.
REQ-027 Reset asserted mid-run SHALL discard the in-flight sample and all results; release SHALL resume in IDLE.

Structure
REQ-028 A shared package andor_pkg SHALL hold the state encoding constants and default WIDTH/CNT_W values.
REQ-029 One sub-module andor_golden SHALL compute the expected AND/OR combinationally from x and y of stage 1.

Verification
REQ-030 Reset then start, samples (x,y,and,or)=(00,10,00,10),(10,10,10,10),(11,01,01,11), stop -> DONE, vec_count=3, err_count=0, pass=1.
REQ-031 RUN, sample (10,01,01,11) (wrong AND) then (11,11,11,10) (wrong OR), stop -> err_count=2, first_err_x=10, first_err_y=01, pass=0.
REQ-032 start, stop with no samples -> DONE after DRAIN, vec_count=0, pass=0.
REQ-033 CNT_W=2, five valid matching samples -> vec_count=11 (saturated), pass=1.
REQ-034 stop coinciding with a mismatching valid sample -> sample counted, err_count=1 in DONE; in_valid during DRAIN/DONE -> counts unchanged.
REQ-035 reset_n low one cycle mid-RUN with a sample in stage 1 -> IDLE, all outputs 0, next start runs cleanly from zero.
